// File: rtl/memory_pkg.sv
// Shared types and constants for the memory-stage slice.
// MEM_TIMEOUT_EN (optional) enables the bus timeout in dmem_ctrl.
package memory_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  localparam int TIMEOUT_LIMIT = 16;
  localparam int TIMEOUT_W     = 4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/memory_dmem_ctrl.sv
// Data-bus handshake FSM for the memory stage.
// With MEM_TIMEOUT_EN defined, an unacknowledged access is abandoned after TIMEOUT_LIMIT cycles.
module dmem_ctrl
  import memory_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic access,
  input  logic misaligned,
  input  logic dmem_ack,
  output logic dmem_req,
  output logic stall,
  output logic timeout
);

  mem_state_t state;

`ifdef MEM_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] busy_cnt;

  // The last counted BUSY cycle drops the request so upstream can move on.
  assign timeout = (state == BUSY) && (busy_cnt == TIMEOUT_W'(TIMEOUT_LIMIT - 1));
`else
  assign timeout = 1'b0;
`endif

  // Gating with rst_n drops the request at once when reset hits mid-access.
  assign dmem_req = rst_n & ((((state == IDLE) & access & ~misaligned)) |
                             ((state == BUSY) & ~timeout));
  assign stall    = dmem_req & ~dmem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
`ifdef MEM_TIMEOUT_EN
      busy_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (dmem_req && !dmem_ack) begin
            state <= BUSY;
`ifdef MEM_TIMEOUT_EN
            busy_cnt <= '0;
`endif
          end
        end
        BUSY: begin
          if (timeout || dmem_ack) begin
            state <= IDLE;
          end
`ifdef MEM_TIMEOUT_EN
          else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/memory.sv
// Pipeline memory stage: issues loads/stores on the data bus and holds the MEM/WB registers.
// Optional bus timeout is enabled by defining MEM_TIMEOUT_EN.
module memory
  import memory_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_data_ex_mem,
  input  logic [31:0] rt_data_ex_mem,
  input  logic        mem_en_ex_mem,
  input  logic        rd_data_sel_ex_mem,
  input  logic        rd_en_ex_mem,
  input  logic [4:0]  rd_addr_ex_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic        rd_en_mem_wb,
  output logic [4:0]  rd_addr_mem_wb,
  output logic [31:0] rd_data_mem_wb,
  output logic        align_err,
  output logic        bus_err
);

  logic access;
  logic misaligned;
  logic timeout;

  assign access     = mem_en_ex_mem | (rd_data_sel_ex_mem & rd_en_ex_mem);
  assign misaligned = access & is_misaligned(alu_data_ex_mem);

  dmem_ctrl u_dmem_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .access     (access),
    .misaligned (misaligned),
    .dmem_ack   (dmem_ack),
    .dmem_req   (dmem_req),
    .stall      (stall_mem),
    .timeout    (timeout)
  );

  assign dmem_we    = dmem_req & mem_en_ex_mem;
  assign dmem_addr  = {alu_data_ex_mem[31:2], 2'b00};
  assign dmem_wdata = rt_data_ex_mem;

  // A store wins over a load-select, so mem_en kills writeback as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_mem_wb   <= 1'b0;
      rd_addr_mem_wb <= '0;
      rd_data_mem_wb <= '0;
      align_err      <= 1'b0;
    end else begin
      align_err <= misaligned;
      if (stall_mem) begin
        rd_en_mem_wb <= 1'b0;
      end else begin
        rd_en_mem_wb   <= rd_en_ex_mem & ~misaligned & ~mem_en_ex_mem & ~timeout;
        rd_addr_mem_wb <= rd_addr_ex_mem;
        rd_data_mem_wb <= rd_data_sel_ex_mem ? dmem_rdata : alu_data_ex_mem;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err <= 1'b0;
    end else begin
      bus_err <= timeout;
    end
  end
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_memory.sv
// Directed bench for the memory stage with a writeback scoreboard.
// Covers the timeout path when built with MEM_TIMEOUT_EN.
module tb_memory;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_data_ex_mem;
  logic [31:0] rt_data_ex_mem;
  logic        mem_en_ex_mem;
  logic        rd_data_sel_ex_mem;
  logic        rd_en_ex_mem;
  logic [4:0]  rd_addr_ex_mem;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_mem;
  logic        rd_en_mem_wb;
  logic [4:0]  rd_addr_mem_wb;
  logic [31:0] rd_data_mem_wb;
  logic        align_err;
  logic        bus_err;

  typedef struct {
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
  } wb_t;

  wb_t sb_q[$];
  wb_t model_wb;
  int  checks = 0;
  int  errors = 0;

  memory dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .alu_data_ex_mem    (alu_data_ex_mem),
    .rt_data_ex_mem     (rt_data_ex_mem),
    .mem_en_ex_mem      (mem_en_ex_mem),
    .rd_data_sel_ex_mem (rd_data_sel_ex_mem),
    .rd_en_ex_mem       (rd_en_ex_mem),
    .rd_addr_ex_mem     (rd_addr_ex_mem),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_ack           (dmem_ack),
    .dmem_rdata         (dmem_rdata),
    .stall_mem          (stall_mem),
    .rd_en_mem_wb       (rd_en_mem_wb),
    .rd_addr_mem_wb     (rd_addr_mem_wb),
    .rd_data_mem_wb     (rd_data_mem_wb),
    .align_err          (align_err),
    .bus_err            (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] alu, input logic [31:0] rt, input logic mem_en,
                                input logic sel, input logic rd_en, input logic [4:0] rd_addr,
                                input logic ack, input logic [31:0] rdata);
    @(negedge clk);
    alu_data_ex_mem    = alu;
    rt_data_ex_mem     = rt;
    mem_en_ex_mem      = mem_en;
    rd_data_sel_ex_mem = sel;
    rd_en_ex_mem       = rd_en;
    rd_addr_ex_mem     = rd_addr;
    dmem_ack           = ack;
    dmem_rdata         = rdata;
  endtask

  // Checks request/stall for the current cycle, predicts the MEM/WB load, then compares after the edge.
  task automatic run_cycle(input string tag, input logic exp_req, input logic exp_stall, input logic kill_wb);
    wb_t e;
    logic mis;
    #1;
    check_output({tag, "_req"}, 32'(dmem_req), 32'(exp_req));
    check_output({tag, "_stall"}, 32'(stall_mem), 32'(exp_stall));
    mis = (mem_en_ex_mem | (rd_data_sel_ex_mem & rd_en_ex_mem)) & (alu_data_ex_mem[1:0] != 2'b00);
    if (exp_stall) begin
      e       = model_wb;
      e.rd_en = 1'b0;
    end else begin
      e.rd_en   = rd_en_ex_mem & ~mis & ~mem_en_ex_mem & ~kill_wb;
      e.rd_addr = rd_addr_ex_mem;
      e.rd_data = rd_data_sel_ex_mem ? dmem_rdata : alu_data_ex_mem;
    end
    model_wb = e;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_output({tag, "_wb_en"}, 32'(rd_en_mem_wb), 32'(e.rd_en));
    check_output({tag, "_wb_addr"}, 32'(rd_addr_mem_wb), 32'(e.rd_addr));
    check_output({tag, "_wb_data"}, rd_data_mem_wb, e.rd_data);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_req"}, 32'(dmem_req), 32'd0);
    check_output({tag, "_stall"}, 32'(stall_mem), 32'd0);
    check_output({tag, "_wb_en"}, 32'(rd_en_mem_wb), 32'd0);
    check_output({tag, "_wb_addr"}, 32'(rd_addr_mem_wb), 32'd0);
    check_output({tag, "_wb_data"}, rd_data_mem_wb, 32'd0);
    check_output({tag, "_align"}, 32'(align_err), 32'd0);
    check_output({tag, "_bus"}, 32'(bus_err), 32'd0);
  endtask

  initial begin
    rst_n              = 1'b0;
    alu_data_ex_mem    = '0;
    rt_data_ex_mem     = '0;
    mem_en_ex_mem      = 1'b0;
    rd_data_sel_ex_mem = 1'b0;
    rd_en_ex_mem       = 1'b0;
    rd_addr_ex_mem     = '0;
    dmem_ack           = 1'b0;
    dmem_rdata         = '0;
    model_wb           = '{rd_en: 1'b0, rd_addr: 5'd0, rd_data: 32'd0};

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait load
    apply_stimulus(32'h100, 32'h0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 32'hDEADBEEF);
    #1;
    check_output("load_addr", dmem_addr, 32'h100);
    check_output("load_we", 32'(dmem_we), 32'd0);
    run_cycle("load", 1'b1, 1'b0, 1'b0);

    // Store acknowledged after three wait cycles
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(32'h204, 32'h12345678, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, 32'h0);
      #1;
      check_output("store_we", 32'(dmem_we), 32'd1);
      check_output("store_addr", dmem_addr, 32'h204);
      check_output("store_wdata", dmem_wdata, 32'h12345678);
      run_cycle("store_wait", 1'b1, 1'b1, 1'b0);
    end
    apply_stimulus(32'h204, 32'h12345678, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 32'h0);
    run_cycle("store_ack", 1'b1, 1'b0, 1'b0);

    // Misaligned load
    apply_stimulus(32'h102, 32'h0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 32'hA5A5A5A5);
    run_cycle("misaligned", 1'b0, 1'b0, 1'b0);
    check_output("align_pulse", 32'(align_err), 32'd1);

    // ALU writeback
    apply_stimulus(32'h55, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 32'h0);
    run_cycle("alu", 1'b0, 1'b0, 1'b0);
    check_output("align_clear", 32'(align_err), 32'd0);

    // Store and load-select together: store only
    apply_stimulus(32'h400, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 32'h11112222);
    #1;
    check_output("prec_we", 32'(dmem_we), 32'd1);
    run_cycle("prec", 1'b1, 1'b0, 1'b0);

    // Load that is never acknowledged
    apply_stimulus(32'h300, 32'h0, 1'b0, 1'b1, 1'b1, 5'd10, 1'b0, 32'h0BADF00D);
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      run_cycle("tmo_wait", 1'b1, 1'b1, 1'b0);
      @(negedge clk);
    end
    run_cycle("tmo_hit", 1'b0, 1'b0, 1'b1);
    check_output("bus_err_pulse", 32'(bus_err), 32'd1);
    apply_stimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    run_cycle("tmo_after", 1'b0, 1'b0, 1'b0);
    check_output("bus_err_clear", 32'(bus_err), 32'd0);
    apply_stimulus(32'h308, 32'h0, 1'b0, 1'b1, 1'b1, 5'd12, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      run_cycle("rst_busy", 1'b1, 1'b1, 1'b0);
      @(negedge clk);
    end
`else
    for (int i = 0; i < 20; i++) begin
      run_cycle("hang_wait", 1'b1, 1'b1, 1'b0);
      @(negedge clk);
    end
    check_output("bus_err_tied", 32'(bus_err), 32'd0);
`endif

    // Reset in the middle of an access
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    model_wb = '{rd_en: 1'b0, rd_addr: 5'd0, rd_data: 32'd0};
    apply_stimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'hFFFFFFFF);
    rst_n = 1'b1;
    run_cycle("late_ack", 1'b0, 1'b0, 1'b0);

    apply_stimulus(32'h77, 32'h0, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 32'h0);
    run_cycle("post_reset_alu", 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: alu_data_ex_mem  in  32  effective address / ALU result.
REQ-004 SHALL have ports: rt_data_ex_mem  in  32  store data.
REQ-005 SHALL have ports: mem_en_ex_mem  in  1  store request.
REQ-006 SHALL have ports: rd_data_sel_ex_mem  in  1  load (1) / ALU result (0) writeback select.
REQ-007 SHALL have ports: rd_en_ex_mem, rd_addr_ex_mem  in  1, 5  writeback enable and register.
REQ-008 SHALL have ports: dmem_req, dmem_we  out  1, 1  data-bus request and write strobe.
REQ-009 SHALL have ports: dmem_addr, dmem_wdata  out  32, 32  word address, store data.
REQ-010 SHALL have ports: dmem_ack, dmem_rdata  in  1, 32  bus completion, load data.
REQ-011 SHALL have ports: stall_mem  out  1  freeze request to upstream stages.
REQ-012 SHALL have ports: rd_en_mem_wb, rd_addr_mem_wb, rd_data_mem_wb  out  1, 5, 32  writeback pipeline registers.
REQ-013 SHALL have ports: align_err, bus_err  out  1, 1  one-cycle registered error pulses.

Function
REQ-014 SHALL define access = mem_en_ex_mem | (rd_data_sel_ex_mem & rd_en_ex_mem); misaligned = access & (alu_data_ex_mem[1:0] != 0).
REQ-015 SHALL define store precedence: if mem_en_ex_mem and rd_data_sel_ex_mem are both 1, perform a store only, with writeback suppressed.
REQ-016 SHALL use FSM states IDLE and BUSY; IDLE->BUSY when dmem_req & ~dmem_ack; BUSY->IDLE on dmem_ack (or timeout, REQ-031).
REQ-017 SHALL drive dmem_req combinationally = (IDLE & access & ~misaligned) | BUSY.
REQ-018 SHALL drive dmem_we = dmem_req & mem_en_ex_mem.
REQ-019 SHALL drive dmem_addr = {alu_data_ex_mem[31:2], 2'b00}.
REQ-020 SHALL drive dmem_wdata = rt_data_ex_mem.
REQ-021 SHALL drive stall_mem = dmem_req & ~dmem_ack; a same-cycle ack SHALL give a zero-wait access with no stall.
REQ-022 SHALL require the upstream stage to hold all *_ex_mem inputs stable while stall_mem=1; the block SHALL NOT re-sample them in BUSY.
REQ-023 SHALL, on each posedge with stall_mem=1, load rd_en_mem_wb<=0 (bubble) and hold rd_addr/rd_data.
REQ-024 SHALL, on each posedge with stall_mem=0, load rd_addr_mem_wb<=rd_addr_ex_mem and rd_en_mem_wb<=rd_en_ex_mem & ~misaligned & ~mem_en_ex_mem.
REQ-025 SHALL, on each posedge with stall_mem=0, load rd_data_mem_wb<=(rd_data_sel_ex_mem ? dmem_rdata : alu_data_ex_mem).
REQ-026 SHALL, for a misaligned access, issue no bus request, no stall, and pulse align_err=1 for exactly the following cycle.
REQ-027 SHALL ignore dmem_ack while dmem_req=0.

Reset
REQ-028 SHALL, while rst_n=0, force state=IDLE and timeout counter=0, asynchronously.
REQ-029 SHALL, while rst_n=0, force rd_en_mem_wb=0, rd_addr_mem_wb=0, rd_data_mem_wb=0, align_err=0 and bus_err=0, asynchronously.
REQ-030 SHALL, on reset asserted mid-access, drop dmem_req immediately; any later ack SHALL be ignored per REQ-027.

Configuration
REQ-031 SHALL, with MEM_TIMEOUT_EN defined, count BUSY cycles in a 4-bit counter cleared on entry to BUSY.
REQ-032 SHALL, on the 16th BUSY cycle without ack, return to IDLE, deassert dmem_req and stall_mem, suppress writeback, and pulse bus_err for one cycle.
REQ-033 SHALL, without MEM_TIMEOUT_EN, wait for ack indefinitely, tie bus_err to 0, and contain no counter logic.

Structure
REQ-034 SHALL place the FSM state enumeration and the timeout limit constant (16) in the shared defines header.
REQ-035 SHALL implement the bus handshake/FSM as one sub-module, dmem_ctrl; the pipeline registers SHALL stay in memory.

Verification
REQ-036 SHALL cover: load, addr 0x100, ack same cycle, rdata 0xDEADBEEF, rd_addr 5 -> no stall; next cycle rd_en_mem_wb=1, rd_addr_mem_wb=5, rd_data_mem_wb=0xDEADBEEF.
REQ-037 SHALL cover: store, addr 0x204, wdata 0x12345678, ack after 3 cycles -> dmem_we=1 and stall_mem=1 for 3 cycles, three bubbles, then rd_en_mem_wb=0.
REQ-038 SHALL cover: load, addr 0x102 -> dmem_req never asserted; align_err=1 for one cycle; rd_en_mem_wb=0.
REQ-039 SHALL cover: ALU op, alu_data 0x55, rd_en=1, rd_addr 3 -> no request; next cycle rd_data_mem_wb=0x55, rd_en_mem_wb=1.
REQ-040 SHALL cover, with MEM_TIMEOUT_EN defined: no ack -> stall for 16 cycles, bus_err pulses, FSM returns to IDLE; without the macro, stall persists.
REQ-041 SHALL cover: rst_n=0 in BUSY -> dmem_req=0, all outputs at reset values; a late ack after release causes no writeback.
